// File: rtl/button_event_gen.sv
// Converts a debounced button level into press/release/long/repeat event pulses.
// Define BUTTON_AUTO_REPEAT_EN to enable periodic repeat pulses while held long.
module button_event_gen #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       held_long,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {StIdle, StPressed, StLong} state_e;

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);

  state_e           state_q;
  logic             btn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise;
  logic             fall;

  always_comb begin
    rise = btn_level & ~btn_q;
    fall = ~btn_level & btn_q;
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);
`else
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = (REPEAT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      btn_q         <= 1'b0;
      cnt_q         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held_long     <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      btn_q         <= btn_level;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (rise) begin
            state_q     <= StPressed;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
          end
        end
        StPressed: begin
          // Release wins over reaching the long threshold in the same cycle
          if (fall) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            release_pulse <= 1'b1;
          end else if (cnt_q == LongLast) begin
            state_q    <= StLong;
            cnt_q      <= '0;
            long_pulse <= 1'b1;
            held_long  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StLong: begin
          if (fall) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            release_pulse <= 1'b1;
            held_long     <= 1'b0;
          end
`ifdef BUTTON_AUTO_REPEAT_EN
          else if (cnt_q == RepeatLast) begin
            cnt_q        <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`else
          else begin
            cnt_q <= '0;
          end
`endif
        end
        default: begin
          state_q   <= StIdle;
          cnt_q     <= '0;
          held_long <= 1'b0;
        end
      endcase
    end
  end

endmodule
